cmos_byte_tx: RTL and testbench
===============================

CMOS_BYTE_TX -- requirements
Module: cmos_byte_tx

Interface
REQ-001 Parameter H_ACT, default 640: active pixels per line.
REQ-002 Parameter V_ACT, default 480: active lines per frame.
REQ-003 Parameter H_BLANK, default 144: HREF-low clocks after each active line.
REQ-004 Parameter VSYNC_LINES, default 3: line periods with CMOS_VSYNC high.
REQ-005 Parameter V_BACK, default 17: blank line periods between VSYNC fall and first active line.
REQ-006 Parameter FIFO_DEPTH, default 4, a power of 2 and at least 2: pixel FIFO entries.
REQ-007 Reset iRST_N is asynchronous and active-low; clock is CMOS_oCLK.
REQ-008 CMOS_oCLK  in  1  byte clock; all logic on its rising edge.
REQ-009 iRST_N  in  1  asynchronous active-low reset.
REQ-010 frame_start  in  1  request one frame; sampled only in IDLE.
REQ-011 pix_data  in  16  pixel word, high byte first on the wire.
REQ-012 pix_valid / pix_ready  in / out  1 / 1  push handshake into the pixel FIFO.
REQ-013 DATA  out  8  byte stream.
REQ-014 HREF  out  1  high during active bytes.
REQ-015 CMOS_VSYNC  out  1  frame sync, active high.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 underrun  out  1  one-cycle pulse when a pixel is popped from an empty FIFO.

Function
REQ-018 Line period SHALL be LP = 2*H_ACT + H_BLANK clocks, counted by an hcnt wrapping at LP-1.
REQ-019 FSM states SHALL be IDLE, VSYNC, VBACK, ACTIVE, FRAME_END.
REQ-020 IDLE with frame_start=1 -> VSYNC; CMOS_VSYNC=1 in the next cycle with hcnt=0 and the line counter at 0.
REQ-021 VSYNC SHALL last exactly VSYNC_LINES*LP clocks, then -> VBACK; VBACK SHALL last V_BACK*LP clocks, then -> ACTIVE.
REQ-022 In ACTIVE, for hcnt < 2*H_ACT: HREF=1; even hcnt drives pix[15:8], odd hcnt drives pix[7:0] from the same pixel.
REQ-023 For hcnt >= 2*H_ACT in ACTIVE, and in every other state: HREF=0 and DATA=8'h00.
REQ-024 After V_ACT line periods in ACTIVE -> FRAME_END for one clock, then -> IDLE; busy SHALL fall in the IDLE cycle.
REQ-025 frame_start SHALL be ignored while busy=1; no request queueing.
REQ-026 FIFO pop SHALL occur at each even active hcnt; the low byte is held in a register for the odd cycle.
REQ-027 Pop on empty: the pixel SHALL be 16'h0000, underrun=1 in that cycle, and the FSM continues unstalled.
REQ-028 pix_ready = FIFO not full; push on pix_valid&pix_ready; a push and a pop in the same cycle are both honoured and occupancy is unchanged.
REQ-029 The FIFO SHALL NOT be flushed at frame start or end; prefill in IDLE is permitted.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy is held in a counter of width log2(FIFO_DEPTH)+1.

Reset
REQ-031 Asserting iRST_N low at any time, mid-frame included, SHALL immediately force FSM=IDLE, DATA=0, HREF=0, CMOS_VSYNC=0, busy=0, underrun=0, and all counters and the FIFO to empty, so pix_ready=1 after release.
REQ-032 After deassertion, no frame SHALL start without a new frame_start.

Structure
REQ-033 A shared package cmos_pkg SHALL hold the FSM state enum and the default timing constants shared with the receive-side byte-pair logic.
REQ-034 The FIFO SHALL be a separate sub-module pix_fifo (parameter DEPTH, 16-bit width, push/pop/full/empty/count).

Verification
Use H_ACT=4, V_ACT=2, H_BLANK=3, VSYNC_LINES=1, V_BACK=1, giving LP=11.
REQ-035 Prefill 8 pixels 16'hA1B2..., then pulse frame_start -> VSYNC high 11 clocks, 11 blank clocks, then per line DATA A1,B2,... over 8 HREF clocks and 3 low clocks; busy low after 46 clocks.
REQ-036 Empty FIFO at frame start -> every active byte is 00 and underrun pulses 8 times, once per even hcnt.
REQ-037 Hold pix_valid=1 continuously -> pix_ready drops at 4 entries, no word is lost or duplicated, and a simultaneous push/pop leaves occupancy at 4.
REQ-038 Pulse frame_start mid-frame -> timing is unchanged and no second frame follows.
REQ-039 Pull iRST_N low during an HREF byte -> all outputs are 0 in the same cycle, pix_ready=1 after release, and the FSM stays idle until frame_start.
REQ-040 Loop back into the existing byte-pair receiver -> reconstructed 16-bit words equal the transmitted pixels in order.

Source files
------------

// File: rtl/cmos_pkg.sv
// cmos_pkg
// Shared definitions for the CMOS byte-stream transmit and receive side:
//   - cmos_state_e   : frame sequencer state encoding
//   - DEF_*          : default sensor timing (640x480, VGA-like blanking)
//   - line_period()  : clocks per line period for a given timing
package cmos_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VSYNC     = 3'd1,
    ST_VBACK     = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_FRAME_END = 3'd4
  } cmos_state_e;

  localparam int DEF_H_ACT       = 640;
  localparam int DEF_V_ACT       = 480;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BACK      = 17;
  localparam int DEF_FIFO_DEPTH  = 4;

  // Each pixel occupies two byte clocks on the wire.
  function automatic int line_period(input int h_act, input int h_blank);
    return 2 * h_act + h_blank;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo
// Small synchronous FIFO for 16-bit pixels between the pixel source and the
// byte serialiser. Push/pop requests are qualified internally against
// full/empty, so a pop on empty and a push on full are both no-ops.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data : write request and data
//   i_pop          : read request; o_data shows the head entry (raw storage,
//                    not meaningful while empty)
//   o_full, o_empty: status flags
//   o_count        : occupancy, 0..DEPTH
module pix_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [15:0]              i_data,
  input  logic                     i_pop,
  output logic [15:0]              o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // Storage needs no reset: entries are only visible after being written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cmos_byte_tx.sv
// cmos_byte_tx
// Emulates a CMOS sensor output: frames of V_ACT lines, each line carrying
// H_ACT 16-bit pixels as two bytes (high byte first) under HREF, framed by a
// VSYNC pulse and vertical back porch. Pixels come from a small FIFO that may
// be prefilled while idle; an empty FIFO yields zero pixels and an underrun
// pulse instead of stalling the raster.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | waiting for frame_start, counters cleared, busy low
// ST_VSYNC     | CMOS_VSYNC high for VSYNC_LINES line periods
// ST_VBACK     | blank line periods before the first active line
// ST_ACTIVE    | V_ACT lines: 2*H_ACT HREF bytes then H_BLANK low clocks
// ST_FRAME_END | single closing clock before returning to idle
//
// Ports:
//   CMOS_oCLK, iRST_N    : byte clock, asynchronous active-low reset
//   frame_start          : one-frame request, honoured only in ST_IDLE
//   pix_data, pix_valid  : pixel push into FIFO; pix_ready = FIFO not full
//   DATA, HREF           : byte stream and its qualifier
//   CMOS_VSYNC           : frame sync, active high
//   busy                 : any state other than ST_IDLE
//   underrun             : pixel popped from an empty FIFO this cycle
module cmos_byte_tx
  import cmos_pkg::*;
#(
  parameter int H_ACT       = DEF_H_ACT,
  parameter int V_ACT       = DEF_V_ACT,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic        CMOS_oCLK,
  input  logic        iRST_N,
  input  logic        frame_start,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  DATA,
  output logic        HREF,
  output logic        CMOS_VSYNC,
  output logic        busy,
  output logic        underrun
);

  localparam int LP = line_period(H_ACT, H_BLANK);
  localparam int HW = $clog2(LP);
  localparam int LW = $clog2(VSYNC_LINES + V_BACK + V_ACT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] HC_LAST  = HW'(LP - 1);
  localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VB_LAST  = LW'(V_BACK - 1);
  localparam logic [LW-1:0] VA_LAST  = LW'(V_ACT - 1);

  cmos_state_e   r_state;
  cmos_state_e   w_state_nx;
  logic [HW-1:0] r_hcnt;
  logic [LW-1:0] r_lcnt;
  logic [7:0]    r_lo;

  logic          w_line_end;
  logic          w_in_href;
  logic          w_pop;
  logic [15:0]   w_fifo_data;
  logic [15:0]   w_pix;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_href;
  logic          w_vsync;
  logic          w_busy;
  logic [7:0]    w_data;

  pix_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pix_fifo (
    .i_clk   (CMOS_oCLK),
    .i_rst_n (iRST_N),
    .i_push  (pix_valid),
    .i_data  (pix_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign pix_ready  = ~w_full;
  assign w_line_end = (r_hcnt == HC_LAST);
  assign w_in_href  = (32'(r_hcnt) < 32'(2 * H_ACT));
  // An empty FIFO substitutes a zero pixel so the raster never stalls.
  assign w_pix      = w_empty ? 16'h0000 : w_fifo_data;

  always_ff @(posedge CMOS_oCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_href     = 1'b0;
    w_vsync    = 1'b0;
    w_busy     = 1'b1;
    w_data     = 8'h00;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (frame_start) w_state_nx = ST_VSYNC;
      end
      ST_VSYNC: begin
        w_vsync = 1'b1;
        if (w_line_end && r_lcnt == VS_LAST) w_state_nx = ST_VBACK;
      end
      ST_VBACK: begin
        if (w_line_end && r_lcnt == VB_LAST) w_state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_in_href) begin
          w_href = 1'b1;
          // Even byte slot fetches a new pixel; odd slot replays its low byte.
          if (!r_hcnt[0]) begin
            w_pop  = 1'b1;
            w_data = w_pix[15:8];
          end else begin
            w_data = r_lo;
          end
        end
        if (w_line_end && r_lcnt == VA_LAST) w_state_nx = ST_FRAME_END;
      end
      ST_FRAME_END: w_state_nx = ST_IDLE;
      default:      w_state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from registered state, so the async reset clears
  // them in the same cycle it is asserted.
  assign DATA       = w_data;
  assign HREF       = w_href;
  assign CMOS_VSYNC = w_vsync;
  assign busy       = w_busy;
  assign underrun   = w_pop & (w_count == '0);

  // hcnt runs continuously across a phase; lcnt counts line periods within
  // the current phase and restarts whenever the phase changes.
  always_ff @(posedge CMOS_oCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
    end else if (r_state == ST_IDLE || r_state == ST_FRAME_END) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
    end else if (w_line_end) begin
      r_hcnt <= '0;
      r_lcnt <= (w_state_nx != r_state) ? '0 : r_lcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  always_ff @(posedge CMOS_oCLK or negedge iRST_N) begin
    if (!iRST_N)    r_lo <= 8'h00;
    else if (w_pop) r_lo <= w_pix[7:0];
  end

endmodule

// File: tb/tb_cmos_byte_tx.sv
module tb_cmos_byte_tx;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HB = 3;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int DEPTH = 4;
  localparam int LP = 2 * HA + HB;
  localparam int BUSY_LEN = LP * (VS + VB + VA) + 1;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  DATA;
  logic        HREF;
  logic        CMOS_VSYNC;
  logic        busy;
  logic        underrun;

  cmos_byte_tx #(
    .H_ACT(HA), .V_ACT(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CMOS_oCLK  (clk),
    .iRST_N     (rst_n),
    .frame_start(frame_start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .DATA       (DATA),
    .HREF       (HREF),
    .CMOS_VSYNC (CMOS_VSYNC),
    .busy       (busy),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel source: offers src[0] until accepted.
  logic [15:0] src[$];
  initial begin
    logic hs;
    pix_valid = 1'b0;
    pix_data  = 16'h0000;
    forever begin
      @(negedge clk);
      hs = pix_valid && pix_ready && rst_n;
      @(posedge clk);
      if (hs && src.size() > 0) void'(src.pop_front());
      #1;
      if (src.size() > 0) begin
        pix_valid = 1'b1;
        pix_data  = src[0];
      end else begin
        pix_valid = 1'b0;
      end
    end
  end

  // Reference model: frame timing from the offset since frame_start was
  // accepted, and the FIFO as a plain queue.
  logic [15:0] mq[$];
  int          m_off = 0;
  logic [7:0]  m_lo = 8'h00;

  // Observations for the literal checks, plus a byte-pair receiver.
  logic [7:0]  cap[$];
  logic [15:0] rx_q[$];
  int          ucnt = 0, vcnt = 0, bcnt = 0;
  logic        rx_ph = 1'b0;
  logic [7:0]  rx_hi = 8'h00;

  always @(negedge clk) begin
    int a, h;
    logic [7:0]  e_data;
    logic        e_href, e_vs, e_busy, e_und, e_rdy, pop, push;
    logic [15:0] px;
    e_data = 8'h00; e_href = 1'b0; e_vs = 1'b0; e_busy = 1'b0; e_und = 1'b0;
    pop = 1'b0; px = 16'h0000;
    if (!rst_n) begin
      mq.delete();
      m_off = 0;
      e_rdy = 1'b1;
    end else begin
      if (m_off > 0) begin
        e_busy = 1'b1;
        if (m_off <= LP * VS) e_vs = 1'b1;
        a = m_off - 1 - LP * (VS + VB);
        if (a >= 0 && a < LP * VA) begin
          h = a % LP;
          if (h < 2 * HA) begin
            e_href = 1'b1;
            if (h % 2 == 0) begin
              pop = 1'b1;
              if (mq.size() > 0) px = mq[0];
              else e_und = 1'b1;
              e_data = px[15:8];
              m_lo   = px[7:0];
            end else begin
              e_data = m_lo;
            end
          end
        end
      end
      e_rdy = (mq.size() < DEPTH);
    end
    chk("DATA", {24'h0, DATA}, {24'h0, e_data});
    chk("HREF", {31'h0, HREF}, {31'h0, e_href});
    chk("VSYNC", {31'h0, CMOS_VSYNC}, {31'h0, e_vs});
    chk("busy", {31'h0, busy}, {31'h0, e_busy});
    chk("underrun", {31'h0, underrun}, {31'h0, e_und});
    chk("pix_ready", {31'h0, pix_ready}, {31'h0, e_rdy});
    if (rst_n) begin
      push = pix_valid && e_rdy;
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (push) mq.push_back(pix_data);
      if (m_off > 0) m_off = (m_off == BUSY_LEN) ? 0 : m_off + 1;
      else if (frame_start) m_off = 1;
    end
    if (HREF) begin
      cap.push_back(DATA);
      if (!rx_ph) begin rx_hi = DATA; rx_ph = 1'b1; end
      else begin rx_q.push_back({rx_hi, DATA}); rx_ph = 1'b0; end
    end else begin
      rx_ph = 1'b0;
    end
    if (underrun)   ucnt++;
    if (CMOS_VSYNC) vcnt++;
    if (busy)       bcnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    cap.delete(); rx_q.delete();
    ucnt = 0; vcnt = 0; bcnt = 0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  initial begin
    logic [7:0]  exp_b[16];
    logic [15:0] exp_w[8];
    int          got;
    exp_w = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718,
              16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18,
              8'h29, 8'h3A, 8'h4B, 8'h5C, 8'h6D, 8'h7E, 8'h8F, 8'h90};
    rst_n = 1'b0;
    frame_start = 1'b0;
    tick(3);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", {31'h0, pix_ready}, 32'h1);
    chk("reset_busy", {31'h0, busy}, 32'h0);

    // Normal frame with prefilled FIFO, refilled during the first line.
    for (int i = 0; i < 8; i++) src.push_back(exp_w[i]);
    tick(6);
    chk("prefill_full_ready", {31'h0, pix_ready}, 32'h0);
    clear_obs();
    pulse_start();
    tick(60);
    chk("t1_bytes", cap.size(), 16);
    for (int i = 0; i < 16 && i < cap.size(); i++)
      chk($sformatf("t1_byte%0d", i), {24'h0, cap[i]}, {24'h0, exp_b[i]});
    chk("t1_words", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      chk($sformatf("t1_rx%0d", i), {16'h0, rx_q[i]}, {16'h0, exp_w[i]});
    chk("t1_vsync_len", vcnt, 11);
    chk("t1_busy_len", bcnt, 45);
    chk("t1_underruns", ucnt, 0);

    // Empty FIFO: zero bytes and one underrun per pixel slot.
    clear_obs();
    pulse_start();
    tick(60);
    chk("t2_underruns", ucnt, 8);
    chk("t2_bytes", cap.size(), 16);
    got = 0;
    foreach (cap[i]) if (cap[i] != 8'h00) got++;
    chk("t2_nonzero", got, 0);

    // Continuous push while streaming, plus an ignored mid-frame request.
    for (int i = 0; i < 20; i++) src.push_back(16'h1000 + 16'(i));
    clear_obs();
    pulse_start();
    tick(20);
    pulse_start();
    tick(80);
    chk("t3_busy_len", bcnt, 45);
    chk("t3_underruns", ucnt, 0);
    chk("t3_words", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      chk($sformatf("t3_rx%0d", i), {16'h0, rx_q[i]}, 32'h1000 + i);
    chk("t3_full_ready", {31'h0, pix_ready}, 32'h0);

    // Reset during an HREF byte.
    clear_obs();
    pulse_start();
    got = 0;
    for (int i = 0; i < 60; i++) begin
      if (HREF) begin got = 1; break; end
      tick(1);
    end
    chk("t4_href_seen", got, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_data", {24'h0, DATA}, 32'h0);
    chk("t4_rst_href", {31'h0, HREF}, 32'h0);
    chk("t4_rst_vsync", {31'h0, CMOS_VSYNC}, 32'h0);
    chk("t4_rst_busy", {31'h0, busy}, 32'h0);
    chk("t4_rst_underrun", {31'h0, underrun}, 32'h0);
    src.delete();
    tick(2);
    rst_n = 1'b1;
    #1;
    chk("t4_ready_after", {31'h0, pix_ready}, 32'h1);
    bcnt = 0;
    tick(40);
    chk("t4_stays_idle", bcnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
